muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_pkg.sv | 33 +++
 rtl/muldiv_step.sv | 26 ++
 rtl/muldiv_sequencer.sv | 129 ++++++++++++
 tb/tb_muldiv_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared ALU control codes and M-extension sequencer state encoding.
// Also imported by the ALU control decoder, so code values must stay in sync there.
package muldiv_sequencer_pkg;

  localparam logic [4:0] ALU_MUL    = 5'b01010;
  localparam logic [4:0] ALU_MULH   = 5'b01011;
  localparam logic [4:0] ALU_MULHSU = 5'b01100;
  localparam logic [4:0] ALU_MULHU  = 5'b01101;
  localparam logic [4:0] ALU_DIV    = 5'b01110;
  localparam logic [4:0] ALU_DIVU   = 5'b01111;
  localparam logic [4:0] ALU_REM    = 5'b10000;
  localparam logic [4:0] ALU_REMU   = 5'b10001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] code);
    return (code >= ALU_MUL) && (code <= ALU_REMU);
  endfunction

  function automatic logic is_div(input logic [4:0] code);
    return (code >= ALU_DIV) && (code <= ALU_REMU);
  endfunction

  function automatic logic is_rem(input logic [4:0] code);
    return (code == ALU_REM) || (code == ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Purely combinational; acc holds {hi, multiplier} or {remainder, dividend/quotient}.
module muldiv_step (
  input  logic        div_mode,
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [32:0] trial;

  always_comb begin
    sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    shifted  = {acc[63:32], acc[31]};
    trial    = shifted - {1'b0, opnd};
    acc_next = {sum, acc[31:1]};
    if (div_mode) begin
      // A borrow out of the 33-bit trial means the divisor did not fit: restore.
      if (trial[32]) acc_next = {shifted[31:0], acc[30:0], 1'b0};
      else           acc_next = {trial[31:0], acc[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: 34 cycles accept-to-done, 1 for divide-by-zero/overflow.
// No backpressure: busy stalls the pipeline; kill aborts silently, done is a one-cycle pulse.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  alu_control,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_t      state;
  logic [4:0]  op;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        neg_res;
  logic        neg_rem;
  logic [4:0]  cnt;

  logic [63:0] step_acc;
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic        fast, div0, ovf;
  logic [31:0] fast_res;
  logic [63:0] prod;
  logic [31:0] quot, rem;
  logic [31:0] fix_res;

  muldiv_step u_step (
    .div_mode (is_div(op)),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (step_acc)
  );

  always_comb begin
    a_signed = (alu_control == ALU_MULH) || (alu_control == ALU_MULHSU) ||
               (alu_control == ALU_DIV)  || (alu_control == ALU_REM);
    b_signed = (alu_control == ALU_MULH) || (alu_control == ALU_DIV) ||
               (alu_control == ALU_REM);
    a_neg    = a_signed & op_a[31];
    b_neg    = b_signed & op_b[31];
    mag_a    = a_neg ? (32'd0 - op_a) : op_a;
    mag_b    = b_neg ? (32'd0 - op_b) : op_b;

    div0     = is_div(alu_control) && (op_b == 32'd0);
    ovf      = ((alu_control == ALU_DIV) || (alu_control == ALU_REM)) &&
               (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    fast     = div0 || ovf;
    if (div0) fast_res = is_rem(alu_control) ? op_a  : 32'hFFFF_FFFF;
    else      fast_res = is_rem(alu_control) ? 32'd0 : 32'h8000_0000;
  end

  always_comb begin
    prod = neg_res ? (64'd0 - acc) : acc;
    quot = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
    rem  = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
    case (op)
      ALU_MUL:                        fix_res = prod[31:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_res = prod[63:32];
      ALU_DIV, ALU_DIVU:              fix_res = quot;
      default:                        fix_res = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      op      <= 5'd0;
      acc     <= 64'd0;
      opnd    <= 32'd0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      cnt     <= 5'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 32'd0;
    end else if (kill) begin
      state <= S_IDLE;
      cnt   <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && is_muldiv(alu_control)) begin
            op      <= alu_control;
            acc     <= {32'd0, mag_a};
            opnd    <= mag_b;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            cnt     <= 5'd0;
            busy    <= 1'b1;
            if (fast) begin
              state  <= S_DONE;
              result <= fast_res;
              done   <= 1'b1;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc <= step_acc;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_res;
          state  <= S_DONE;
          done   <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: latency, results, fast paths, kill and reset.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  alu_control;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .alu_control (alu_control),
    .op_a        (op_a),
    .op_b        (op_b),
    .kill        (kill),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept edge is N; returns cycles until done is seen (done at cycle N+cyc), -1 on timeout.
  task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic busy_ok);
    alu_control = code;
    op_a        = a;
    op_b        = b;
    start       = 1'b1;
    tick();
    start   = 1'b0;
    cyc     = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 100) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic do_op(input string tag, input logic [4:0] code, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int   cyc;
    logic bok;
    run_op(code, a, b, cyc, bok);
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    tick();
  endtask

  initial begin
    int   cyc;
    logic bok;
    logic saw_done;

    reset = 1'b1; start = 1'b0; kill = 1'b0;
    alu_control = 5'd0; op_a = 32'd0; op_b = 32'd0;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b0;
    tick();

    // MULHU all-ones: busy through N+1..N+33, done at N+34, result held afterwards.
    run_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, bok);
    check("mulhu_lat", 32'(cyc), 32'd34);
    check("mulhu_busy", {31'd0, bok}, 32'd1);
    check("mulhu_res", result, 32'hFFFF_FFFE);
    tick();
    check("done_pulse", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    tick(); tick();
    check("mulhu_hold", result, 32'hFFFF_FFFE);

    do_op("div_neg",  ALU_DIV,    32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD);
    do_op("rem_neg",  ALU_REM,    32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF);
    do_op("divu_z",   ALU_DIVU,   32'd7, 32'd0, 1, 32'hFFFF_FFFF);
    do_op("remu_z",   ALU_REMU,   32'd7, 32'd0, 1, 32'd7);
    do_op("div_ovf",  ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    do_op("rem_ovf",  ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
    do_op("mulhsu",   ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFF);
    do_op("mul",      ALU_MUL,    32'd3, 32'd5, 34, 32'd15);
    do_op("mulh",     ALU_MULH,   32'hFFFF_FFFE, 32'd3, 34, 32'hFFFF_FFFF);
    do_op("divu",     ALU_DIVU,   32'd100, 32'd7, 34, 32'd14);

    // Invalid code: no accept, no done.
    alu_control = 5'b00000; op_a = 32'd1; op_b = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("inv_busy", {31'd0, busy}, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("inv_done", {31'd0, saw_done}, 32'd0);

    // Kill sampled at edge N+10 of a DIV; restart at N+11.
    alu_control = ALU_DIV; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_done", {31'd0, saw_done | done}, 32'd0);
    do_op("post_kill", ALU_DIV, 32'hFFFF_FF9C, 32'd7, 34, 32'hFFFF_FFF2);

    // Kill together with start in IDLE: not accepted.
    alu_control = ALU_MUL; op_a = 32'd2; op_b = 32'd2; start = 1'b1; kill = 1'b1;
    tick();
    start = 1'b0; kill = 1'b0;
    check("kill_start", {31'd0, busy}, 32'd0);

    // Start while busy is ignored; original operation completes unchanged.
    alu_control = ALU_MUL; op_a = 32'd6; op_b = 32'd7; start = 1'b1;
    tick();
    alu_control = ALU_DIVU; op_a = 32'd9; op_b = 32'd0;
    tick();
    start = 1'b0;
    cyc = 2;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    check("busy_start_lat", 32'(cyc), 32'd34);
    check("busy_start_res", result, 32'd42);
    tick();

    // Reset mid-operation: discarded, no done, result cleared.
    run_op(ALU_MUL, 32'd3, 32'd5, cyc, bok);
    tick();
    alu_control = ALU_MULHU; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_res", result, 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("rst_mid_done", {31'd0, saw_done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
